uart_tx_dev: RTL and testbench

- Memory-mapped UART transmitter peripheral that sits behind the bridge, next to the two timers.
- The CPU writes bytes through the bridge's device write path. The block serialises them onto a single output line as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- It raises an interrupt request when the transmit path has drained.
- Its IRQ feeds a free HWInt bit at the bridge.

---
 rtl/uart_tx_dev_if.sv | 9 +
 rtl/uart_tx_dev.sv | 87 ++++++++
 tb/tb_uart_tx_dev.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: bridge-side device bus (word address, write strobe, write/read data).
interface uart_tx_dev_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  modport master (output Addr, WE, Din, input Dout);
  modport slave (input Addr, WE, Din, output Dout);
endinterface

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt.
module uart_tx_dev #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_dev_if.slave  bus,
  output logic          IRQ,
  output logic          txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, nxt;
  logic en, im, pend, ovf, tick, pop, push, full, avail, set_pend, clr_pend;
  logic wr_ctrl, wr_div, wr_tx, unused;
  logic [15:0] div, div_eff, baud;
  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] shift, cnt8;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [2:0] bitc;
  logic [1:0] a;
  assign a        = bus.Addr[3:2];
  assign unused   = ^{bus.Addr[31:4], bus.Din[31:16]};
  assign wr_ctrl  = bus.WE && a == 2'd0;
  assign wr_div   = bus.WE && a == 2'd1;
  assign wr_tx    = bus.WE && a == 2'd2;
  assign full     = cnt == FULL_CNT;
  assign push     = wr_tx && !full;
  assign avail    = en && cnt != '0;
  assign div_eff  = div == 16'd0 ? 16'd1 : div;
  // >= so a divisor lowered below the running count ends the bit on the next cycle
  assign tick     = baud >= div_eff - 16'd1;
  assign set_pend = state == STOP && tick && cnt == '0;
  assign clr_pend = (wr_ctrl && bus.Din[2]) || push;
  assign cnt8     = 8'(cnt);
  assign txd      = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign bus.Dout = a == 2'd0 ? {30'd0, im, en} :
                    a == 2'd1 ? {16'd0, div} :
                    a == 2'd3 ? {24'd0, cnt8[2:0], ovf, pend, cnt == '0, full, state != IDLE} : 32'd0;
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      IDLE:  if (avail) begin nxt = START; pop = 1'b1; end
      START: if (tick) nxt = DATA;
      DATA:  if (tick && bitc == 3'd7) nxt = STOP;
      STOP:  if (tick) begin nxt = avail ? START : IDLE; pop = avail; end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus.Din[7:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en    <= 1'b0;
      im    <= 1'b0;
      div   <= DEFAULT_DIV;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      ovf   <= 1'b0;
      IRQ   <= 1'b0;
      shift <= '0;
      bitc  <= '0;
      baud  <= '0;
    end else begin
      if (wr_ctrl) begin en <= bus.Din[0]; im <= bus.Din[1]; end
      if (wr_div) div <= bus.Din[15:0];
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt   <= cnt + CW'(push) - CW'(pop);
      pend  <= clr_pend ? 1'b0 : set_pend ? 1'b1 : pend;
      ovf   <= (wr_ctrl && bus.Din[2]) ? 1'b0 : (wr_tx && full) ? 1'b1 : ovf;
      IRQ   <= im & pend;
      baud  <= (state == IDLE || tick) ? 16'd0 : baud + 16'd1;
      shift <= pop ? mem[rp] : (state == DATA && tick) ? shift >> 1 : shift;
      bitc  <= pop ? 3'd0 : (state == DATA && tick) ? bitc + 3'd1 : bitc;
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed bench with a txd frame decoder checking bytes against a scoreboard queue.
module tb_uart_tx_dev;
  logic clk = 1'b0, reset = 1'b0, irq, txd;
  int checks = 0, failures = 0, cyc = 0, mdiv = 4;
  bit mon_en = 1'b0;
  logic [7:0] q[$];
  int starts[$];
  logic [31:0] d;
  uart_tx_dev_if bus();
  uart_tx_dev #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .IRQ(irq), .txd(txd));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.Addr = {28'd0, a};
    bus.Din = v;
    bus.WE = 1'b1;
    @(posedge clk);
    #1 bus.WE = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.Addr = {28'd0, a};
    bus.WE = 1'b0;
    #1 v = bus.Dout;
  endtask
  // Frame decoder: detect start at a falling edge, sample each bit mid-period.
  initial begin
    logic [7:0] b;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        starts.push_back(cyc);
        repeat (mdiv / 2) @(negedge clk);
        chk("start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (mdiv) @(negedge clk);
          b[i] = txd;
        end
        repeat (mdiv) @(negedge clk);
        chk("stop_bit", 32'(txd), 32'd1);
        exp = q.size() != 0 ? {24'd0, q.pop_front()} : 32'hxxxxxxxx;
        chk("frame_byte", {24'd0, b}, exp);
      end
    end
  end
  initial begin
    bus.Addr = '0;
    bus.Din = '0;
    bus.WE = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    // reset state
    rd(0, d); chk("rst_ctrl", d, 32'd0);
    rd(1, d); chk("rst_div", d, 32'd434);
    rd(2, d); chk("rst_txdata", d, 32'd0);
    rd(3, d); chk("rst_status", d, 32'h04);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    // single frame, DIV=4, interrupt
    wr(1, 32'd4);
    wr(0, 32'h3);
    mdiv = 4;
    mon_en = 1'b1;
    q.push_back(8'hA5);
    wr(2, 32'hA5);
    @(posedge clk); #1;
    chk("start_latency", 32'(txd), 32'd0);
    repeat (39) @(posedge clk);
    rd(3, d); chk("stat_last_stop", d, 32'h05);
    @(posedge clk);
    rd(3, d); chk("stat_pend", d, 32'h0C);
    chk("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'd1);
    wr(0, 32'h7);
    @(posedge clk); #1;
    chk("irq_clear", 32'(irq), 32'd0);
    rd(3, d); chk("stat_cleared", d, 32'h04);
    chk("sb_empty_a5", q.size(), 32'd0);
    // five back-to-back bytes, DIV=2
    wr(1, 32'd2);
    mdiv = 2;
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      q.push_back(8'(i));
      wr(2, i);
    end
    rd(3, d); chk("stat_full", d, 32'h83);
    repeat (97) @(posedge clk);
    rd(3, d); chk("stat_burst_done", d, 32'h0C);
    chk("sb_empty_burst", q.size(), 32'd0);
    chk("burst_frames", starts.size(), 32'd5);
    for (int i = 0; i + 1 < starts.size(); i++)
      chk("contiguous", starts[i + 1] - starts[i], 32'd20);
    // overflow with EN=0, then drain
    wr(0, 32'h4);
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q.push_back(8'h30 + 8'(i));
      wr(2, 32'h30 + i);
    end
    rd(3, d); chk("stat_ovf", d, 32'h92);
    repeat (20) @(posedge clk); #1;
    chk("txd_disabled", 32'(txd), 32'd1);
    chk("no_frames_disabled", starts.size(), 32'd0);
    wr(0, 32'h1);
    repeat (85) @(posedge clk);
    rd(3, d); chk("stat_drained", d, 32'h1C);
    chk("sb_empty_ovf", q.size(), 32'd0);
    chk("drain_frames", starts.size(), 32'd4);
    chk("irq_masked", 32'(irq), 32'd0);
    // DIV change mid-frame: 8 -> 3 during data bit 1 (0x5A)
    mon_en = 1'b0;
    wr(0, 32'h5);
    wr(1, 32'd8);
    wr(2, 32'h5A);
    repeat (19) @(posedge clk);
    wr(1, 32'd3);
    chk("div_bit1", 32'(txd), 32'd1);
    for (int b = 2; b < 8; b++) begin
      logic [7:0] v;
      v = 8'h5A;
      @(posedge clk); #1;
      chk("div_bit_first", 32'(txd), 32'(v[b]));
      repeat (2) @(posedge clk); #1;
      chk("div_bit_last", 32'(txd), 32'(v[b]));
    end
    @(posedge clk); #1;
    chk("div_stop", 32'(txd), 32'd1);
    repeat (2) @(posedge clk);
    rd(3, d); chk("div_stop_busy", d, 32'h05);
    @(posedge clk);
    rd(3, d); chk("div_done", d, 32'h0C);
    // async reset during data bit 4
    wr(1, 32'd4);
    wr(2, 32'h00);
    wr(2, 32'h00);
    repeat (21) @(posedge clk);
    #3 chk("pre_reset_txd", 32'(txd), 32'd0);
    reset = 1'b0;
    #1 chk("async_reset_txd", 32'(txd), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd(3, d); chk("post_rst_status", d, 32'h04);
    rd(0, d); chk("post_rst_ctrl", d, 32'd0);
    rd(1, d); chk("post_rst_div", d, 32'd434);
    chk("post_rst_irq", 32'(irq), 32'd0);
    repeat (30) @(posedge clk); #1;
    chk("post_rst_idle", 32'(txd), 32'd1);
    rd(3, d); chk("post_rst_no_frame", d, 32'h04);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
